dial_adc_reader: RTL and testbench
==================================

Name: dial_adc_reader

Overview:
- SPI master for a 12-bit two-channel ADC with MCP3202-style framing. It produces the filtered, debounced `adc_dial_val` that the dial puzzle stage consumes.
- Conversions run at a fixed sample rate. Each result goes through a power-of-two boxcar average, then a hysteresis hold, so position buckets (value[11:9]) do not chatter at boundaries.
- The block sits between the board ADC pins and the puzzle logic.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz
- SCLK_HZ, 1_000_000, SPI clock rate; HALF_DIV = CLK_FREQ/(2*SCLK_HZ), 25 at defaults
- SAMPLE_HZ, 1000, conversion launch rate; SAMPLE_DIV = CLK_FREQ/SAMPLE_HZ
- CHANNEL, 0, ADC channel select (0/1), sent as the ODD bit
- AVG_LOG2, 2, boxcar window = 2^AVG_LOG2 samples
- HYST, 32, minimum LSB change before the held output moves

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  permits new conversion launches
- spi_miso  in  1  ADC data out
- spi_sclk  out  1  SPI clock, idle low
- spi_cs_n  out  1  ADC chip select, active low
- spi_mosi  out  1  command bits to ADC
- adc_dial_val  out  12  filtered, hysteresis-held dial value
- sample_valid  out  1  one-cycle pulse per completed conversion

Behaviour:
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, adc_dial_val=0, sample_valid=0, state=S_IDLE, rate timer=0, window empty (first_done=0).
- Reset mid-frame: all outputs take their reset values on that edge. The frame is abandoned and the ADC sees CS rise.
- Rate timer: loads SAMPLE_DIV-1 at each launch, decrements, and saturates at 0. A launch occurs when state=S_IDLE && enable && timer==0. The first launch is therefore the first enabled cycle after reset.
- FSM states:
  - S_IDLE: cs_n=1. Leave on launch.
  - S_SETUP: cs_n=0, sclk low, mosi=bit1. Hold HALF_DIV cycles.
  - S_XFER: 17 SCLK periods, each HALF_DIV low then HALF_DIV high.
    - Bit index k=1..17. MOSI updates only while sclk is low and is stable before each rising edge.
    - MOSI command: k1 start=1, k2 SGL=1, k3 ODD=CHANNEL, k4 MSBF=1, k5..17 mosi=0.
    - MISO is sampled on the cycle sclk rises. k5 (null bit) is ignored; k6..k17 shift in B11..B0, MSB first.
  - S_HOLD: after the last high phase, sclk=0 and cs_n=1. Hold HALF_DIV cycles (minimum CS-high time).
  - S_FILTER: one cycle. Update the window and hold value, assert sample_valid, return to S_IDLE.
- enable deasserted mid-frame: the frame completes normally, including the filter update. No new launch occurs while enable=0. After re-enable, launch follows the timer rule.
- Averaging:
  - Circular buffer of 2^AVG_LOG2 12-bit entries and a running sum of 12+AVG_LOG2 bits: sum += new - oldest.
  - avg = sum >> AVG_LOG2, truncated.
  - First sample after reset (first_done=0) preloads every entry with it: sum = sample << AVG_LOG2.
- Hysteresis:
  - First sample: adc_dial_val = avg unconditionally.
  - Afterwards: adc_dial_val = avg if |avg - adc_dial_val| >= HYST, or if avg==0, or if avg==4095 (rails always reachable). Otherwise hold.
  - The output changes only on the S_FILTER cycle.
- sample_valid pulses on every S_FILTER cycle, whether or not the output moved.
- Elaboration check: SAMPLE_DIV > 2*HALF_DIV*19+1. Otherwise the launch rate is silently frame-limited.

Decomposition:
- Shared package `dial_adc_pkg`:
  - FRAME_BITS=17, DATA_FIRST_BIT=6, command bit constants
  - FSM state encoding S_IDLE/S_SETUP/S_XFER/S_HOLD/S_FILTER
  - ADC_W=12
- Sub-module `dial_adc_filter`: boxcar window, running sum, preload and hysteresis. Inputs sample/valid, outputs held value. It is verified standalone.
- The SPI FSM and timers stay in the top module.

Test Plan:
- Reset then enable=1, ADC model returns 0xA5C → cs_n falls the cycle after the first enabled edge; MOSI sequence 1,1,0,1 on rising edges k1..k4; sclk period 50 clk; after the frame, adc_dial_val=0xA5C and one sample_valid pulse.
- First sample 0x800, then four samples 0x840 (AVG_LOG2=2, HYST=32) → avg 0x810, 0x820, 0x830, 0x840; adc_dial_val 0x800, 0x820, 0x820, 0x840.
- Held at 0x400, model alternates 0x408/0x3F8 for 20 samples → adc_dial_val stays 0x400; sample_valid pulses 20 times, spaced 50000 clk.
- Held at 0xFE8, model returns 0xFFF repeatedly → output reaches 0xFFF once avg hits 4095, despite the diff being <HYST.
- enable dropped at k=9 → frame completes to 17 bits and the filter updates; no cs_n fall while enable=0; re-enable after the timer expires → launch the next cycle.
- rst asserted at k=10 → next edge: cs_n=1, sclk=0, adc_dial_val=0, sample_valid=0; the next conversion preloads the window.

Source files
------------

// File: rtl/dial_adc_pkg.sv
// Shared constants, FSM encoding and command-bit helper for the dial ADC reader.
package dial_adc_pkg;

   localparam int unsigned ADC_W          = 12;
   localparam int unsigned FRAME_BITS     = 17;
   localparam int unsigned DATA_FIRST_BIT = 6;
   localparam int unsigned BIT_W          = 5;

   localparam logic CMD_START = 1'b1;
   localparam logic CMD_SGL   = 1'b1;
   localparam logic CMD_MSBF  = 1'b1;

   localparam logic [ADC_W-1:0] ADC_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_XFER,
      S_HOLD,
      S_FILTER
   } state_t;

   // MOSI level for frame bit k (1-based); bits past MSBF are don't-care, driven low.
   function automatic logic cmd_bit(input logic [BIT_W-1:0] k, input logic odd);
      case (k)
         BIT_W'(1): cmd_bit = CMD_START;
         BIT_W'(2): cmd_bit = CMD_SGL;
         BIT_W'(3): cmd_bit = odd;
         BIT_W'(4): cmd_bit = CMD_MSBF;
         default:   cmd_bit = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dial_adc_filter.sv
// Boxcar average over 2^AVG_LOG2 samples followed by a hysteresis hold.
module dial_adc_filter
   import dial_adc_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = 2,
   parameter int unsigned HYST     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADC_W-1:0] sample_i,
   input  logic             valid_i,
   output logic [ADC_W-1:0] value_o
);

   localparam int unsigned DEPTH = 1 << AVG_LOG2;
   localparam int unsigned SUM_W = ADC_W + AVG_LOG2;
   localparam int unsigned PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

   logic [ADC_W-1:0] win_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             first_done_q, first_done_d;
   logic [ADC_W-1:0] held_q, held_d;
   logic [ADC_W-1:0] avg_c, diff_c;

   // Running-sum update, average and hysteresis decision for an incoming sample.
   always_comb begin
      sum_d        = sum_q;
      ptr_d        = ptr_q;
      held_d       = held_q;
      first_done_d = first_done_q;
      avg_c        = '0;
      diff_c       = '0;
      if (valid_i) begin
         if (!first_done_q) begin
            // Preload: the whole window looks like this sample, so the average is the sample.
            sum_d        = SUM_W'(sample_i) << AVG_LOG2;
            ptr_d        = '0;
            held_d       = sample_i;
            first_done_d = 1'b1;
         end else begin
            sum_d  = sum_q + SUM_W'(sample_i) - SUM_W'(win_q[ptr_q]);
            ptr_d  = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
            avg_c  = ADC_W'(sum_d >> AVG_LOG2);
            diff_c = (avg_c >= held_q) ? (avg_c - held_q) : (held_q - avg_c);
            if ((32'(diff_c) >= HYST) || (avg_c == '0) || (avg_c == ADC_MAX)) begin
               held_d = avg_c;
            end
         end
      end
   end

   // Window storage; contents are only meaningful once first_done is set.
   always_ff @(posedge clk) begin
      if (valid_i) begin
         if (!first_done_q) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               win_q[i] <= sample_i;
            end
         end else begin
            win_q[ptr_q] <= sample_i;
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q        <= '0;
         ptr_q        <= '0;
         first_done_q <= 1'b0;
         held_q       <= '0;
      end else begin
         sum_q        <= sum_d;
         ptr_q        <= ptr_d;
         first_done_q <= first_done_d;
         held_q       <= held_d;
      end
   end

   assign value_o = held_q;

endmodule

// File: rtl/dial_adc_reader.sv
// SPI master for an MCP3202-style ADC feeding a filtered, hysteresis-held dial value.
module dial_adc_reader
   import dial_adc_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned SCLK_HZ   = 1_000_000,
   parameter int unsigned SAMPLE_HZ = 1000,
   parameter int unsigned CHANNEL   = 0,
   parameter int unsigned AVG_LOG2  = 2,
   parameter int unsigned HYST      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             spi_miso,
   output logic             spi_sclk,
   output logic             spi_cs_n,
   output logic             spi_mosi,
   output logic [ADC_W-1:0] adc_dial_val,
   output logic             sample_valid
);

   localparam int unsigned HALF_DIV   = CLK_FREQ / (2 * SCLK_HZ);
   localparam int unsigned SAMPLE_DIV = CLK_FREQ / SAMPLE_HZ;
   localparam int unsigned DIV_W      = $clog2(HALF_DIV + 1);
   localparam int unsigned TMR_W      = $clog2(SAMPLE_DIV + 1);
   localparam logic        ODD_BIT    = 1'(CHANNEL % 2);

   // Launch period must exceed a full frame, otherwise the rate is silently frame-limited.
   if (SAMPLE_DIV <= 2 * HALF_DIV * 19 + 1) begin : g_rate_check
      $error("dial_adc_reader: SAMPLE_DIV too small for the SPI frame length");
   end

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               sclk_q, sclk_d;
   logic               cs_n_q, cs_n_d;
   logic               mosi_q, mosi_d;
   logic [ADC_W-1:0]   shift_q, shift_d;
   logic               valid_q, valid_d;
   logic               filt_valid_c;
   logic               phase_end_c;

   assign phase_end_c = (div_q == DIV_W'(HALF_DIV - 1));

   // Frame sequencing, SCLK generation, command shifting and MISO capture.
   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      bit_d        = bit_q;
      tmr_d        = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
      sclk_d       = sclk_q;
      cs_n_d       = cs_n_q;
      mosi_d       = mosi_q;
      shift_d      = shift_q;
      valid_d      = 1'b0;
      filt_valid_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            if (enable && (tmr_q == '0)) begin
               state_d = S_SETUP;
               cs_n_d  = 1'b0;
               mosi_d  = cmd_bit(BIT_W'(1), ODD_BIT);
               div_d   = '0;
               tmr_d   = TMR_W'(SAMPLE_DIV - 1);
            end
         end
         S_SETUP: begin
            if (phase_end_c) begin
               state_d = S_XFER;
               div_d   = '0;
               bit_d   = BIT_W'(1);
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_XFER: begin
            if (!phase_end_c) begin
               div_d = div_q + DIV_W'(1);
            end else begin
               div_d = '0;
               if (!sclk_q) begin
                  // Rising edge: the ADC has held MISO stable through the low phase.
                  sclk_d = 1'b1;
                  if (bit_q >= BIT_W'(DATA_FIRST_BIT)) begin
                     shift_d = {shift_q[ADC_W-2:0], spi_miso};
                  end
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == BIT_W'(FRAME_BITS)) begin
                     state_d = S_HOLD;
                     cs_n_d  = 1'b1;
                     mosi_d  = 1'b0;
                  end else begin
                     bit_d  = bit_q + BIT_W'(1);
                     mosi_d = cmd_bit(bit_q + BIT_W'(1), ODD_BIT);
                  end
               end
            end
         end
         S_HOLD: begin
            if (phase_end_c) begin
               // Filter result and valid pulse both become visible during S_FILTER.
               state_d      = S_FILTER;
               div_d        = '0;
               valid_d      = 1'b1;
               filt_valid_c = 1'b1;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_FILTER: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         tmr_q   <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         shift_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         tmr_q   <= tmr_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
      end
   end

   dial_adc_filter #(
      .AVG_LOG2 (AVG_LOG2),
      .HYST     (HYST)
   ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .sample_i (shift_q),
      .valid_i  (filt_valid_c),
      .value_o  (adc_dial_val)
   );

   assign spi_sclk     = sclk_q;
   assign spi_cs_n     = cs_n_q;
   assign spi_mosi     = mosi_q;
   assign sample_valid = valid_q;

endmodule

// File: tb/tb_dial_adc_reader.sv
// Self-checking bench for dial_adc_reader with a behavioural ADC and filter model.
`timescale 1ns/1ps
module tb_dial_adc_reader;

   localparam int unsigned CLK_FREQ  = 50_000_000;
   localparam int unsigned SCLK_HZ   = 5_000_000;
   localparam int unsigned SAMPLE_HZ = 125_000;
   localparam int unsigned CHANNEL   = 0;
   localparam int unsigned AVG_LOG2  = 2;
   localparam int unsigned HYST      = 32;
   localparam int HD  = CLK_FREQ / (2 * SCLK_HZ);
   localparam int SD  = CLK_FREQ / SAMPLE_HZ;
   localparam int WIN = 1 << AVG_LOG2;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        spi_miso;
   logic        spi_sclk;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic [11:0] adc_dial_val;
   logic        sample_valid;

   int    n_tests = 0;
   int    n_fail  = 0;
   longint cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dial_adc_reader #(
      .CLK_FREQ (CLK_FREQ), .SCLK_HZ (SCLK_HZ), .SAMPLE_HZ (SAMPLE_HZ),
      .CHANNEL (CHANNEL), .AVG_LOG2 (AVG_LOG2), .HYST (HYST)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .spi_miso     (spi_miso),
      .spi_sclk     (spi_sclk),
      .spi_cs_n     (spi_cs_n),
      .spi_mosi     (spi_mosi),
      .adc_dial_val (adc_dial_val),
      .sample_valid (sample_valid)
   );

   // ---------------- ADC pin model ----------------
   logic [11:0] adc_next = 12'h000;
   logic [11:0] frame_val;
   logic [16:0] mosi_vec;
   int          rise_cnt = 0;
   int          cs_falls = 0;
   time         t_r1, t_r2;

   always @(negedge spi_cs_n) begin
      frame_val = adc_next;
      rise_cnt  = 0;
      mosi_vec  = '0;
      spi_miso  = 1'b0;
      cs_falls++;
   end

   always @(posedge spi_sclk) begin
      if (!spi_cs_n) begin
         rise_cnt++;
         mosi_vec = {mosi_vec[15:0], spi_mosi};
         if (rise_cnt == 1) t_r1 = $time;
         if (rise_cnt == 2) t_r2 = $time;
      end
   end

   // ADC shifts its next bit out after each falling SCLK; bit k=6..17 carries B11..B0.
   always @(negedge spi_sclk) begin
      int nxt;
      nxt = rise_cnt + 1;
      if (!spi_cs_n && nxt >= 6 && nxt <= 17) spi_miso = frame_val[17 - nxt];
      else spi_miso = 1'b0;
   end

   // ---------------- Filter reference model ----------------
   int m_win[$];
   bit m_first = 1'b0;
   int m_held  = 0;

   function automatic void model_reset();
      m_win.delete();
      m_first = 1'b0;
      m_held  = 0;
   endfunction

   function automatic void model_push(int s);
      int sum, avg, d;
      if (!m_first) begin
         m_win.delete();
         for (int i = 0; i < WIN; i++) m_win.push_back(s);
         m_held  = s;
         m_first = 1'b1;
         return;
      end
      m_win.push_back(s);
      void'(m_win.pop_front());
      sum = 0;
      foreach (m_win[i]) sum += m_win[i];
      avg = sum / WIN;
      d = (avg > m_held) ? avg - m_held : m_held - avg;
      if (d >= int'(HYST) || avg == 0 || avg == 4095) m_held = avg;
   endfunction

   // ---------------- Stimulus utilities ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst    = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   // Queue a value for the next frame and wait (bounded) for its sample_valid pulse.
   task automatic run_conv(input logic [11:0] v, output bit ok, output longint t);
      adc_next = v;
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < 3 * SD; i++) begin
         tick();
         if (sample_valid) begin
            ok = 1'b1;
            t  = cyc;
            break;
         end
      end
   endtask

   // ---------------- Tests ----------------
   task automatic test_reset();
      rst = 1'b1; enable = 1'b0;
      repeat (4) tick();
      n_tests++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got=%b want=1", spi_cs_n); end
      n_tests++; if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b want=0", spi_sclk); end
      n_tests++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b want=0", spi_mosi); end
      n_tests++; if (adc_dial_val !== 12'h000) begin n_fail++; $display("FAIL reset_val got=%h want=000", adc_dial_val); end
      n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", sample_valid); end
   endtask

   task automatic test_first_frame();
      bit ok;
      longint t;
      rst = 1'b0;
      model_reset();
      tick();
      adc_next = 12'hA5C;
      enable   = 1'b1;
      tick();
      n_tests++; if (spi_cs_n !== 1'b0) begin n_fail++; $display("FAIL first_launch cs_n got=%b want=0", spi_cs_n); end
      run_conv(12'hA5C, ok, t);
      model_push(12'hA5C);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL first_valid timeout got=0 want=1"); end
      n_tests++; if (adc_dial_val !== 12'hA5C) begin n_fail++; $display("FAIL first_val got=%h want=a5c", adc_dial_val); end
      n_tests++; if (rise_cnt != 17) begin n_fail++; $display("FAIL first_rises got=%0d want=17", rise_cnt); end
      n_tests++; if (mosi_vec !== {1'b1, 1'b1, 1'(CHANNEL), 1'b1, 13'b0}) begin
         n_fail++; $display("FAIL first_mosi got=%b want=%b", mosi_vec, {1'b1, 1'b1, 1'(CHANNEL), 1'b1, 13'b0});
      end
      n_tests++; if ((t_r2 - t_r1) != time'(2 * HD * 10)) begin
         n_fail++; $display("FAIL sclk_period got=%0t want=%0d", t_r2 - t_r1, 2 * HD * 10);
      end
      tick();
      n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL valid_width got=%b want=0", sample_valid); end
   endtask

   task automatic test_avg_sequence();
      bit ok;
      longint t;
      logic [11:0] want [5] = '{12'h800, 12'h800, 12'h820, 12'h820, 12'h840};
      logic [11:0] v;
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         v = (i == 0) ? 12'h800 : 12'h840;
         run_conv(v, ok, t);
         model_push(int'(v));
         n_tests++; if (!ok || adc_dial_val !== want[i]) begin
            n_fail++; $display("FAIL avg_seq[%0d] ok=%b got=%h want=%h", i, ok, adc_dial_val, want[i]);
         end
      end
   endtask

   task automatic test_hold_chatter();
      bit ok;
      longint t, t_prev;
      logic [11:0] v;
      do_reset();
      enable = 1'b1;
      run_conv(12'h400, ok, t_prev);
      model_push(12'h400);
      for (int i = 0; i < 20; i++) begin
         v = (i % 2 == 0) ? 12'h408 : 12'h3F8;
         run_conv(v, ok, t);
         model_push(int'(v));
         n_tests++; if (!ok || adc_dial_val !== 12'h400 || int'(adc_dial_val) != m_held) begin
            n_fail++; $display("FAIL chatter_hold[%0d] ok=%b got=%h want=400", i, ok, adc_dial_val);
         end
         n_tests++; if (t - t_prev != longint'(SD)) begin
            n_fail++; $display("FAIL chatter_spacing[%0d] got=%0d want=%0d", i, t - t_prev, SD);
         end
         t_prev = t;
      end
   endtask

   task automatic test_rail();
      bit ok;
      longint t;
      do_reset();
      enable = 1'b1;
      run_conv(12'hFE8, ok, t);
      model_push(12'hFE8);
      for (int i = 0; i < 5; i++) begin
         run_conv(12'hFFF, ok, t);
         model_push(12'hFFF);
         n_tests++; if (!ok || int'(adc_dial_val) != m_held) begin
            n_fail++; $display("FAIL rail_step[%0d] ok=%b got=%h want=%h", i, ok, adc_dial_val, 12'(m_held));
         end
      end
      n_tests++; if (adc_dial_val !== 12'hFFF) begin n_fail++; $display("FAIL rail_final got=%h want=fff", adc_dial_val); end
   endtask

   task automatic test_random();
      bit ok;
      longint t;
      int cur;
      do_reset();
      enable = 1'b1;
      cur = int'($urandom_range(0, 4095));
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 3) == 0) cur = int'($urandom_range(0, 4095));
         else cur = cur + int'($urandom_range(0, 160)) - 80;
         if (cur < 0) cur = 0;
         if (cur > 4095) cur = 4095;
         run_conv(12'(cur), ok, t);
         model_push(cur);
         n_tests++; if (!ok || int'(adc_dial_val) != m_held) begin
            n_fail++; $display("FAIL random[%0d] in=%h ok=%b got=%h want=%h", i, 12'(cur), ok, adc_dial_val, 12'(m_held));
         end
      end
   endtask

   task automatic test_enable_drop();
      bit ok;
      longint t;
      int f0;
      logic [11:0] v;
      enable = 1'b1;
      v = 12'($urandom_range(0, 4095));
      adc_next = v;
      f0 = cs_falls;
      for (int i = 0; i < 3 * SD && cs_falls == f0; i++) tick();
      for (int i = 0; i < 3 * SD && rise_cnt < 9; i++) tick();
      enable = 1'b0;
      run_conv(v, ok, t);
      model_push(int'(v));
      n_tests++; if (!ok || rise_cnt != 17) begin n_fail++; $display("FAIL drop_frame ok=%b rises=%0d want=17", ok, rise_cnt); end
      n_tests++; if (int'(adc_dial_val) != m_held) begin
         n_fail++; $display("FAIL drop_val got=%h want=%h", adc_dial_val, 12'(m_held));
      end
      f0 = cs_falls;
      repeat (2 * SD) tick();
      n_tests++; if (cs_falls != f0 || spi_cs_n !== 1'b1) begin
         n_fail++; $display("FAIL drop_no_launch falls=%0d want=0", cs_falls - f0);
      end
      v = 12'($urandom_range(0, 4095));
      adc_next = v;
      enable = 1'b1;
      tick();
      n_tests++; if (spi_cs_n !== 1'b0) begin n_fail++; $display("FAIL reenable_launch cs_n got=%b want=0", spi_cs_n); end
      run_conv(v, ok, t);
      model_push(int'(v));
      n_tests++; if (!ok || int'(adc_dial_val) != m_held) begin
         n_fail++; $display("FAIL reenable_val ok=%b got=%h want=%h", ok, adc_dial_val, 12'(m_held));
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      longint t;
      int f0;
      logic [11:0] v;
      enable = 1'b1;
      adc_next = 12'h123;
      f0 = cs_falls;
      for (int i = 0; i < 3 * SD && cs_falls == f0; i++) tick();
      for (int i = 0; i < 3 * SD && rise_cnt < 10; i++) tick();
      rst = 1'b1;
      tick();
      n_tests++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL midrst_cs_n got=%b want=1", spi_cs_n); end
      n_tests++; if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk got=%b want=0", spi_sclk); end
      n_tests++; if (adc_dial_val !== 12'h000) begin n_fail++; $display("FAIL midrst_val got=%h want=000", adc_dial_val); end
      n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b want=0", sample_valid); end
      model_reset();
      v = 12'($urandom_range(64, 4000));
      adc_next = v;
      rst = 1'b0;
      run_conv(v, ok, t);
      model_push(int'(v));
      n_tests++; if (!ok || adc_dial_val !== v) begin
         n_fail++; $display("FAIL midrst_preload ok=%b got=%h want=%h", ok, adc_dial_val, v);
      end
      v = 12'($urandom_range(0, 4095));
      run_conv(v, ok, t);
      model_push(int'(v));
      n_tests++; if (!ok || int'(adc_dial_val) != m_held) begin
         n_fail++; $display("FAIL midrst_after ok=%b got=%h want=%h", ok, adc_dial_val, 12'(m_held));
      end
   endtask

   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      spi_miso = 1'b0;
      test_reset();
      test_first_frame();
      test_avg_sequence();
      test_hold_chatter();
      test_rail();
      test_random();
      test_enable_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
